calc_sequencer: RTL and testbench

- FSM that drives the calculator datapath through one infix expression stored in ROM and terminated by '#'.
- Reads ROM symbols in order and assembles multi-digit operands (up to 3 digits).
- Converts infix to postfix on the fly, shunting-yard style, using the operand and operator stacks, then drains both stacks.
- Sits directly above the datapath; every datapath control input is driven only by this block.

---
 rtl/calc_pkg.sv | 8 +
 rtl/calc_reduce_seq.sv | 34 +++
 rtl/calc_sequencer.sv | 139 +++++++++++++
 tb/tb_calc_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, operator/ROM symbol codes and reduction constants for the calculator sequencer
package calc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_NPUSH, S_OPCHK, S_RED, S_DRAIN, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {R_R2, R_R1, R_RO, R_RX, R_RP} red_step_t;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MULT = 2'd2, OP_DIV = 2'd3;
  localparam logic [4:0] SYM_HASH = 5'd10, SYM_OP_MIN = 5'd20, SYM_OP_MAX = 5'd30;
  localparam int RED_LEN = 5;
endpackage

// File: rtl/calc_reduce_seq.sv
// calc_reduce_seq: 5-step reduction micro-sequencer (pop op2, pop op1, pop operator, latch result, push result)
module calc_reduce_seq
  import calc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  output logic o_busy,
  output logic o_last,
  output logic o_op2_en,
  output logic o_op1_en,
  output logic o_operand_pop,
  output logic o_operator_en,
  output logic o_operator_pop,
  output logic o_result_en,
  output logic o_sel,
  output logic o_operand_push
);
  red_step_t r_step;
  always_ff @(posedge clk)
    r_step <= (rst || !i_go || o_last) ? R_R2 : red_step_t'(r_step + 3'd1);
  always_comb begin
    o_busy         = i_go;
    o_last         = i_go && int'(r_step) == RED_LEN - 1;
    o_op2_en       = i_go && r_step == R_R2;
    o_op1_en       = i_go && r_step == R_R1;
    o_operand_pop  = o_op2_en || o_op1_en;
    o_operator_en  = i_go && r_step == R_RO;
    o_operator_pop = o_operator_en;
    o_result_en    = i_go && r_step == R_RX;
    o_operand_push = i_go && r_step == R_RP;
    o_sel          = o_operand_push;
  end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: drives the calculator datapath through one '#'-terminated infix ROM expression (shunting-yard).
// Define CALC_ERR_EN to trap digit overflow / illegal symbols in a sticky ERR state with an err output.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int MAX_LEN    = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_operand,
  input  logic       is_operator,
  input  logic       is_hash,
  input  logic       is_lt,
  input  logic       is_empty,
  output logic       num0_en,
  output logic       num1_en,
  output logic       num2_en,
  output logic       index_cnt,
  output logic       sel,
  output logic [1:0] mode,
  output logic       operand_push,
  output logic       operand_pop,
  output logic       operator_push,
  output logic       operator_pop,
  output logic       num_clr,
  output logic       op2_en,
  output logic       op1_en,
  output logic       operator_en,
  output logic       result_en,
  output logic       busy,
  output logic       done
`ifdef CALC_ERR_EN
  ,
  output logic       err
`endif
);
  localparam logic [1:0] MAXD = 2'(MAX_DIGITS);
  localparam logic [7:0] LEN  = 8'(MAX_LEN);
  state_t     r_state, w_next;
  logic       r_ret;
  logic [1:0] r_cnt;
  logic [7:0] r_sym;
  logic       w_end, w_dig, w_ovf, w_ill, w_red;
  logic       w_rs_busy, w_rs_last, w_rs_push, w_rs_sel;
  calc_reduce_seq u_red (
    .clk           (clk),
    .rst           (rst),
    .i_go          (r_state == S_RED),
    .o_busy        (w_rs_busy),
    .o_last        (w_rs_last),
    .o_op2_en      (op2_en),
    .o_op1_en      (op1_en),
    .o_operand_pop (operand_pop),
    .o_operator_en (operator_en),
    .o_operator_pop(operator_pop),
    .o_result_en   (result_en),
    .o_sel         (w_rs_sel),
    .o_operand_push(w_rs_push)
  );
  always_comb begin
    // running out of ROM symbols behaves exactly like reading the terminator
    w_end         = is_hash || r_sym == LEN;
    w_dig         = is_operand && r_cnt < MAXD;
    w_ovf         = is_operand && r_cnt == MAXD;
    w_ill         = !is_operand && !is_operator && !is_hash && r_cnt == 2'd0;
    w_red         = !is_empty && is_lt;
    w_next        = r_state;
    num0_en       = 1'b0;
    num1_en       = 1'b0;
    num2_en       = 1'b0;
    index_cnt     = 1'b0;
    mode          = 2'd0;
    num_clr       = 1'b0;
    operator_push = 1'b0;
    done          = 1'b0;
`ifdef CALC_ERR_EN
    err           = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        num_clr = start;
        w_next  = start ? S_SCAN : S_IDLE;
      end
      S_SCAN: begin
        if (w_end) w_next = (r_cnt != 2'd0) ? S_NPUSH : S_DRAIN;
        else if (w_dig) begin
          num0_en   = r_cnt == 2'd0;
          num1_en   = r_cnt == 2'd1;
          num2_en   = r_cnt == 2'd2;
          index_cnt = 1'b1;
        end else if (w_ovf || w_ill) begin
`ifdef CALC_ERR_EN
          w_next    = S_ERR;
`else
          index_cnt = 1'b1;
`endif
        end else w_next = (r_cnt != 2'd0) ? S_NPUSH : S_OPCHK;
      end
      S_NPUSH: begin
        mode    = r_cnt - 2'd1;
        num_clr = 1'b1;
        w_next  = S_SCAN;
      end
      S_OPCHK: begin
        operator_push = !w_red;
        index_cnt     = !w_red;
        w_next        = w_red ? S_RED : S_SCAN;
      end
      S_RED:   w_next = w_rs_last ? (r_ret ? S_DRAIN : S_OPCHK) : S_RED;
      S_DRAIN: w_next = is_empty ? S_DONE : S_RED;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
`ifdef CALC_ERR_EN
      S_ERR:   err = 1'b1;
`endif
      default: w_next = S_IDLE;
    endcase
    operand_push = r_state == S_NPUSH || w_rs_push;
    sel          = w_rs_sel;
    busy         = w_rs_busy || r_state inside {S_SCAN, S_NPUSH, S_OPCHK, S_DRAIN};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ret   <= 1'b0;
      r_cnt   <= 2'd0;
      r_sym   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_ret   <= (r_state == S_DRAIN) ? 1'b1 : (r_state == S_OPCHK) ? 1'b0 : r_ret;
      r_cnt   <= (r_state == S_NPUSH) ? 2'd0 : r_cnt + {1'b0, num0_en | num1_en | num2_en};
      r_sym   <= r_sym + {7'd0, index_cnt};
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: datapath model closes the loop; expected results come from a precedence evaluator.
module tb_calc_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic is_operand, is_operator, is_hash, is_lt, is_empty;
  logic num0_en, num1_en, num2_en, index_cnt, sel, operand_push, operand_pop;
  logic operator_push, operator_pop, num_clr, op2_en, op1_en, operator_en, result_en, busy, done;
  logic [1:0] mode;
  logic [17:0] outs;
`ifdef CALC_ERR_EN
  logic err;
`endif
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .is_operand(is_operand), .is_operator(is_operator), .is_hash(is_hash),
    .is_lt(is_lt), .is_empty(is_empty),
    .num0_en(num0_en), .num1_en(num1_en), .num2_en(num2_en), .index_cnt(index_cnt),
    .sel(sel), .mode(mode), .operand_push(operand_push), .operand_pop(operand_pop),
    .operator_push(operator_push), .operator_pop(operator_pop), .num_clr(num_clr),
    .op2_en(op2_en), .op1_en(op1_en), .operator_en(operator_en), .result_en(result_en),
    .busy(busy), .done(done)
`ifdef CALC_ERR_EN
    , .err(err)
`endif
  );

  assign outs = {num0_en, num1_en, num2_en, index_cnt, sel, mode, operand_push, operand_pop,
                 operator_push, operator_pop, num_clr, op2_en, op1_en, operator_en, result_en,
                 busy, done};

  // datapath model: ROM, digit registers, converter, stacks, ALU
  logic [7:0] rom [128];
  logic [6:0] idx = 7'd0;
  logic [7:0] sym;
  int dreg [3];
  int ostk [64];
  int opstk [64];
  int osp = 0, opsp = 0, op1 = 0, op2 = 0, opc = 0, res = 0, data_out;

  function automatic int prec(int op);
    return op >= 2 ? 1 : 0;
  endfunction

  function automatic int alu(int a, int b, int op);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      default: return b == 0 ? 0 : a / b;
    endcase
  endfunction

  always_comb begin
    sym         = rom[idx];
    is_operand  = sym < 8'd10;
    is_hash     = sym == 8'd10;
    is_operator = sym >= 8'd20 && sym <= 8'd30;
    is_empty    = opsp == 0;
    is_lt       = 1'b0;
    if (opsp > 0) is_lt = prec(opstk[opsp-1]) >= prec(int'(sym) - 20);
    data_out = 0;
    if (osp > 0) data_out = ostk[osp-1];
  end

  always @(posedge clk) begin
    if (rst) begin
      idx  <= 7'd0;
      osp  <= 0;
      opsp <= 0;
    end else begin
      if (num_clr) dreg <= '{0, 0, 0};
      if (num0_en) dreg[0] <= int'(sym);
      if (num1_en) dreg[1] <= int'(sym);
      if (num2_en) dreg[2] <= int'(sym);
      if (index_cnt) idx <= idx + 7'd1;
      if (operand_push) begin
        ostk[osp] <= sel ? res : (mode == 2'd0) ? dreg[0] : (mode == 2'd1) ? dreg[0]*10 + dreg[1]
                                : dreg[0]*100 + dreg[1]*10 + dreg[2];
        osp <= osp + 1;
      end
      if (operand_pop && osp > 0) osp <= osp - 1;
      if (op2_en && osp > 0) op2 <= ostk[osp-1];
      if (op1_en && osp > 0) op1 <= ostk[osp-1];
      if (operator_push) begin
        opstk[opsp] <= int'(sym) - 20;
        opsp <= opsp + 1;
      end
      if (operator_pop && opsp > 0) begin
        opc  <= opstk[opsp-1];
        opsp <= opsp - 1;
      end
      if (result_en) res <= alu(op1, op2, opc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard queues and monitor
  int exp_q[$], mode_q[$], nred_q[$];
  int red_cnt = 0, m_exp;

  always @(negedge clk) begin
    if (rst) red_cnt = 0;
    else begin
      if (operand_push && !sel) begin
        if (mode_q.size() == 0) chk("unexpected_push_mode", int'(mode), -1);
        else begin
          m_exp = mode_q.pop_front();
          chk("push_mode", int'(mode), m_exp);
        end
      end
      if (result_en) red_cnt++;
      if (op1_en && op2_en) chk("op1_op2_overlap", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          m_exp = exp_q.pop_front();
          chk("data_out", data_out, m_exp);
          m_exp = nred_q.pop_front();
          chk("reductions", red_cnt, m_exp);
          chk("busy_at_done", int'(busy), 0);
        end
        red_cnt = 0;
      end
    end
  end

  function automatic logic [7:0] enc(logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ? c - 8'h30 : (c == "#") ? 8'd10 : (c == "+") ? 8'd20
         : (c == "-") ? 8'd21 : (c == "*") ? 8'd22 : 8'd23;
  endfunction

  // reset, load ROM and queue the operand digit-count modes for the expression
  task automatic load(input string s, output int nops);
    int run_len;
    logic [7:0] c;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 128; i++) rom[i] = 8'd10;
    nops = 0;
    run_len = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      rom[i] = enc(c);
      if (c >= 8'h30 && c <= 8'h39) run_len++;
      else begin
        if (run_len > 0) mode_q.push_back((run_len > 3 ? 3 : run_len) - 1);
        run_len = 0;
        if (c != "#") nops++;
      end
    end
    if (run_len > 0) mode_q.push_back((run_len > 3 ? 3 : run_len) - 1);
    rst = 1'b0;
  endtask

  task automatic run(input string s, input int expv, output int cyc);
    int nops;
    load(s, nops);
    exp_q.push_back(expv);
    nred_q.push_back(nops);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      chk({"timeout ", s}, cyc, -1);
      exp_q.delete();
      nred_q.delete();
      mode_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic int eval(int nums[$], int ops[$]);
    int terms[$], adds[$];
    int cur = nums[0];
    int r;
    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i] >= 2) cur = (ops[i] == 2) ? cur * nums[i+1] : cur / nums[i+1];
      else begin
        terms.push_back(cur);
        adds.push_back(ops[i]);
        cur = nums[i+1];
      end
    end
    terms.push_back(cur);
    r = terms[0];
    for (int i = 0; i < adds.size(); i++) r = (adds[i] == 0) ? r + terms[i+1] : r - terms[i+1];
    return r;
  endfunction

  task automatic rand_expr(output string s, output int v);
    int nums[$], ops[$];
    int n, nd, dig, val, op;
    string opch;
    s = "";
    n = $urandom_range(1, 5);
    for (int k = 0; k < n; k++) begin
      nd = $urandom_range(1, 3);
      val = 0;
      for (int d = 0; d < nd; d++) begin
        dig = $urandom_range(0, 9);
        if (k > 0 && ops[k-1] == 3 && d == nd - 1 && val == 0 && dig == 0) dig = 1;
        val = val * 10 + dig;
        s = {s, $sformatf("%0d", dig)};
      end
      nums.push_back(val);
      if (k < n - 1) begin
        op = $urandom_range(0, 3);
        ops.push_back(op);
        opch = (op == 0) ? "+" : (op == 1) ? "-" : (op == 2) ? "*" : "/";
        s = {s, opch};
      end
    end
    s = {s, "#"};
    v = eval(nums, ops);
  endtask

  initial begin
    int cyc, v, nops, k;
    string s;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", int'(outs), 0);
    run("12+3#", 15, cyc);
    run("9*2-5#", 13, cyc);
    run("123+4#", 127, cyc);
    run("7#", 7, cyc);
    chk("latency_7", cyc, 6);
`ifdef CALC_ERR_EN
    load("1234#", nops);
    mode_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("err_set", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("err_sticky", int'(err), 1);
`else
    run("1234#", 123, cyc);
`endif
    s = "";
    for (int i = 0; i < 63; i++) s = {s, "1+"};
    s = {s, "11"};
    run(s, 74, cyc);
    load("9*2-5#", nops);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!op1_en && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_r1", int'(op1_en), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs", int'(outs), 0);
    mode_q.delete();
    run("5+5#", 10, cyc);
    repeat (25) begin
      rand_expr(s, v);
      run(s, v, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
